mem_access_stage: RTL

//  Memory stage directly downstream of the EX/MEM pipeline register. Forwards FU0-2 results to

---
 rtl/mem_access_stage_pkg.sv | 30 +++
 rtl/mem_access_stage_if.sv | 23 ++
 rtl/lsu_lane_align.sv | 61 ++++++
 rtl/mem_access_stage.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_stage_pkg.sv
// Shared types and constants for the memory-access stage: funct3 encodings,
// LSU FSM states and the latched request record.
package mem_access_stage_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned NBYTES = XLEN / 8;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } lsu_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [2:0]      funct3;
    logic [1:0]      lane;
  } lsu_req_t;

  function automatic logic f3_defined(input logic [2:0] f3);
    return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Request/acknowledge data-memory bus between the memory stage and data memory.
interface mem_access_stage_if;
  import mem_access_stage_pkg::*;

  logic              mem_req;
  logic              mem_we;
  logic [XLEN-1:0]   mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [NBYTES-1:0] mem_be;
  logic              mem_ack;
  logic [XLEN-1:0]   mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ack, mem_rdata
  );

endinterface

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane logic: store byte enables / replicated data and
// misalignment detection on the request side, load extract and extension on the response side.
module lsu_lane_align
  import mem_access_stage_pkg::*;
(
  input  logic [2:0]        st_funct3,
  input  logic [1:0]        st_lane,
  input  logic [XLEN-1:0]   st_data,
  input  logic [2:0]        ld_funct3,
  input  logic [1:0]        ld_lane,
  input  logic [XLEN-1:0]   ld_rdata,
  output logic [NBYTES-1:0] be_c,
  output logic [XLEN-1:0]   wdata_c,
  output logic              misalign_c,
  output logic              bad_op_c,
  output logic [XLEN-1:0]   ld_data_c
);

  logic [XLEN-1:0] ld_shift;

  assign ld_shift = ld_rdata >> {ld_lane, 3'b000};

  // Request side: the low two funct3 bits select the access size.
  always_comb begin
    be_c       = '0;
    wdata_c    = '0;
    misalign_c = 1'b0;
    bad_op_c   = !f3_defined(st_funct3);
    case (st_funct3[1:0])
      2'b00: begin
        be_c    = NBYTES'(4'b0001 << st_lane);
        wdata_c = {4{st_data[7:0]}};
      end
      2'b01: begin
        be_c       = NBYTES'(4'b0011 << st_lane);
        wdata_c    = {2{st_data[15:0]}};
        misalign_c = st_lane[0];
      end
      2'b10: begin
        be_c       = '1;
        wdata_c    = st_data;
        misalign_c = (st_lane != 2'b00);
      end
      default: ;
    endcase
  end

  // Response side: shift the addressed lane down, then sign or zero extend.
  always_comb begin
    ld_data_c = '0;
    case (ld_funct3)
      F3_B:    ld_data_c = {{(XLEN-8){ld_shift[7]}}, ld_shift[7:0]};
      F3_H:    ld_data_c = {{(XLEN-16){ld_shift[15]}}, ld_shift[15:0]};
      F3_W:    ld_data_c = ld_shift;
      F3_BU:   ld_data_c = {{(XLEN-8){1'b0}}, ld_shift[7:0]};
      F3_HU:   ld_data_c = {{(XLEN-16){1'b0}}, ld_shift[15:0]};
      default: ld_data_c = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory stage: registers FU results through to completion and runs one LSU
// load/store at a time against a req/ack data memory, with alignment and timeout faults.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [2:0]          tunnel_in,
  input  logic [XLEN-1:0]     rd_result_fu0_in,
  input  logic [XLEN-1:0]     rd_result_fu1_in,
  input  logic [XLEN-1:0]     rd_result_fu2_in,
  input  logic [XLEN-1:0]     pc_fu0_in,
  input  logic [XLEN-1:0]     pc_fu1_in,
  input  logic [XLEN-1:0]     pc_fu2_in,
  input  logic                op_read_in,
  input  logic                op_write_in,
  input  logic [3:0]          op_in,
  input  logic [XLEN-1:0]     pc_lsu_in,
  input  logic [XLEN-1:0]     result_lsu_in,
  input  logic [XLEN-1:0]     store_data_in,
  mem_access_stage_if.master  mem,
  output logic [2:0]          fu_valid_out,
  output logic [XLEN-1:0]     rd_result_fu0_out,
  output logic [XLEN-1:0]     rd_result_fu1_out,
  output logic [XLEN-1:0]     rd_result_fu2_out,
  output logic [XLEN-1:0]     pc_fu0_out,
  output logic [XLEN-1:0]     pc_fu1_out,
  output logic [XLEN-1:0]     pc_fu2_out,
  output logic                lsu_valid_out,
  output logic [XLEN-1:0]     lsu_pc_out,
  output logic [XLEN-1:0]     lsu_data_out,
  output logic                lsu_fault_out,
  output logic                lsu_busy
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT);

  lsu_state_e        state_q, state_d;
  lsu_req_t          req_q, req_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
  logic [NBYTES-1:0] mem_be_q, mem_be_d;
  logic              valid_q, valid_d;
  logic [XLEN-1:0]   pc_out_q, pc_out_d;
  logic [XLEN-1:0]   data_out_q, data_out_d;
  logic              fault_q, fault_d;
  logic              busy_q, busy_d;

  logic [NBYTES-1:0] st_be_c;
  logic [XLEN-1:0]   st_wdata_c;
  logic              misalign_c;
  logic              bad_op_c;
  logic [XLEN-1:0]   ld_data_c;
  logic              reject_c;
  logic              unused_op_bit;

  assign unused_op_bit = op_in[3];

  lsu_lane_align u_align (
    .st_funct3  (op_in[2:0]),
    .st_lane    (result_lsu_in[1:0]),
    .st_data    (store_data_in),
    .ld_funct3  (req_q.funct3),
    .ld_lane    (req_q.lane),
    .ld_rdata   (mem.mem_rdata),
    .be_c       (st_be_c),
    .wdata_c    (st_wdata_c),
    .misalign_c (misalign_c),
    .bad_op_c   (bad_op_c),
    .ld_data_c  (ld_data_c)
  );

  assign reject_c = (op_read_in & op_write_in) | misalign_c | bad_op_c;

  // FU results bypass the LSU entirely and are never stalled.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fu_valid_out      <= '0;
      rd_result_fu0_out <= '0;
      rd_result_fu1_out <= '0;
      rd_result_fu2_out <= '0;
      pc_fu0_out        <= '0;
      pc_fu1_out        <= '0;
      pc_fu2_out        <= '0;
    end else begin
      fu_valid_out      <= tunnel_in;
      rd_result_fu0_out <= rd_result_fu0_in;
      rd_result_fu1_out <= rd_result_fu1_in;
      rd_result_fu2_out <= rd_result_fu2_in;
      pc_fu0_out        <= pc_fu0_in;
      pc_fu1_out        <= pc_fu1_in;
      pc_fu2_out        <= pc_fu2_in;
    end
  end

  // LSU FSM state and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      req_q       <= '0;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      valid_q     <= 1'b0;
      pc_out_q    <= '0;
      data_out_q  <= '0;
      fault_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      valid_q     <= valid_d;
      pc_out_q    <= pc_out_d;
      data_out_q  <= data_out_d;
      fault_q     <= fault_d;
      busy_q      <= busy_d;
    end
  end

  // Next state; completion results hold until the next op completes.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    valid_d     = 1'b0;
    pc_out_d    = pc_out_q;
    data_out_d  = data_out_q;
    fault_d     = fault_q;
    case (state_q)
      ST_IDLE: begin
        if (op_read_in | op_write_in) begin
          req_d = '{pc: pc_lsu_in, funct3: op_in[2:0], lane: result_lsu_in[1:0]};
          if (reject_c) begin
            state_d    = ST_DONE;
            valid_d    = 1'b1;
            pc_out_d   = pc_lsu_in;
            data_out_d = '0;
            fault_d    = 1'b1;
          end else begin
            state_d     = ST_ACCESS;
            cnt_d       = '0;
            mem_req_d   = 1'b1;
            mem_we_d    = op_write_in;
            mem_addr_d  = {result_lsu_in[XLEN-1:2], 2'b00};
            mem_wdata_d = st_wdata_c;
            mem_be_d    = st_be_c;
          end
        end
      end
      ST_ACCESS: begin
        if (mem.mem_ack) begin
          state_d    = ST_DONE;
          valid_d    = 1'b1;
          pc_out_d   = req_q.pc;
          data_out_d = mem_we_q ? '0 : ld_data_c;
          fault_d    = 1'b0;
          mem_req_d  = 1'b0;
          mem_we_d   = 1'b0;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d    = ST_DONE;
          valid_d    = 1'b1;
          pc_out_d   = req_q.pc;
          data_out_d = '0;
          fault_d    = 1'b1;
          mem_req_d  = 1'b0;
          mem_we_d   = 1'b0;
        end else begin
          cnt_d = CNT_W'(cnt_q + 1'b1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign mem.mem_be    = mem_be_q;

  assign lsu_valid_out = valid_q;
  assign lsu_pc_out    = pc_out_q;
  assign lsu_data_out  = data_out_q;
  assign lsu_fault_out = fault_q;
  assign lsu_busy      = busy_q;

endmodule
